// File: rtl/dmem_access_ctrl_if.sv
// Signal bundle between the MEM stage / loader / data RAM and the access controller.
// Latency: n/a (wires only).
// Backpressure: Stall toward the pipeline, Ld_Ack completion toward the loader.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // MEM-stage side
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              Stall;

    // loader / debug side
    logic              Ld_Req;
    logic              Ld_We;
    logic [ADDR_W-1:0] Ld_Addr;
    logic [DATA_W-1:0] Ld_WData;
    logic              Ld_Ack;
    logic [DATA_W-1:0] Ld_RData;

    // data RAM side
    logic              Mem_En;
    logic              Mem_We;
    logic [ADDR_W-3:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_WData;
    logic [DATA_W-1:0] Mem_RData;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, Stall,
        output Ld_Req, Ld_We, Ld_Addr, Ld_WData,
        input  Ld_Ack, Ld_RData,
        input  Mem_En, Mem_We, Mem_Addr, Mem_WData,
        output Mem_RData
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, Stall,
        input  Ld_Req, Ld_We, Ld_Addr, Ld_WData,
        output Ld_Ack, Ld_RData,
        output Mem_En, Mem_We, Mem_Addr, Mem_WData,
        input  Mem_RData
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Arbitrates the single-port sync-read data RAM between the MEM stage and a loader port.
// Latency: CPU store 1 cycle, CPU load data at t+1, loader Ld_Ack at grant+1.
// Backpressure: Stall freezes the pipeline while a MEM access is pending; loader holds Ld_Req until Ld_Ack.
module dmem_access_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    dmem_access_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        LD_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              cpu_req;
    logic              starve;
    logic              cpu_grant;
    logic              ld_grant;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              stall;

    logic [DATA_W-1:0] rd_hold;
    logic [DATA_W-1:0] ld_hold;

    // Byte-offset bits never reach the word-addressed RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.Address[1:0], bus.Ld_Addr[1:0]};

    assign cpu_req = bus.MemRead | bus.MemWrite;
    assign starve  = (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        state_nxt = state;
        cpu_grant = 1'b0;
        ld_grant  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = bus.Address[ADDR_W-1:2];
        mem_wdata = bus.WriteData;
        stall     = 1'b0;

        unique case (state)
            IDLE: begin
                if (cpu_req && !(starve && bus.Ld_Req)) begin
                    cpu_grant = 1'b1;
                    mem_en    = 1'b1;
                    // a simultaneous read+write request is serviced as a store
                    mem_we    = bus.MemWrite;
                    if (!bus.MemWrite) begin
                        stall     = 1'b1;
                        state_nxt = CPU_RD;
                    end
                end else if (bus.Ld_Req) begin
                    ld_grant  = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = bus.Ld_We;
                    mem_addr  = bus.Ld_Addr[ADDR_W-1:2];
                    mem_wdata = bus.Ld_WData;
                    stall     = cpu_req;
                    state_nxt = LD_DONE;
                end
            end
            CPU_RD: begin
                state_nxt = IDLE;
            end
            LD_DONE: begin
                stall     = cpu_req;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counts pipeline wins while the loader waits; any loader grant or idle loader resets it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            starve_cnt <= '0;
        end else if (!bus.Ld_Req || ld_grant) begin
            starve_cnt <= '0;
        end else if (cpu_grant && !starve) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rd_hold <= '0;
            ld_hold <= '0;
        end else begin
            if (state == CPU_RD) begin
                rd_hold <= bus.Mem_RData;
            end
            if (state == LD_DONE) begin
                ld_hold <= bus.Mem_RData;
            end
        end
    end

    // Reset gates the combinational strobes so a request held during reset cannot touch the RAM.
    assign bus.Mem_En    = mem_en & Rst;
    assign bus.Mem_We    = mem_we & Rst;
    assign bus.Mem_Addr  = mem_addr;
    assign bus.Mem_WData = mem_wdata;
    assign bus.Stall     = stall & Rst;

    assign bus.Ld_Ack    = (state == LD_DONE);
    assign bus.ReadData  = (state == CPU_RD)  ? bus.Mem_RData : rd_hold;
    assign bus.Ld_RData  = (state == LD_DONE) ? bus.Mem_RData : ld_hold;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural RAM and read-data scoreboards.
module tb_dmem_access_ctrl;

    logic Clk;
    logic Rst;

    int total = 0;
    int bad   = 0;

    logic [31:0] cpu_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] mem     [0:255];
    logic [31:0] last_rd;
    logic [31:0] last_ld;

    dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_access_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // synchronous-read single-port RAM
    always @(posedge Clk) begin
        if (bus.Mem_En) begin
            if (bus.Mem_We) mem[bus.Mem_Addr[7:0]] <= bus.Mem_WData;
            else            bus.Mem_RData <= mem[bus.Mem_Addr[7:0]];
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag);
        logic [31:0] e;
        if (cpu_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, bus.ReadData);
        end else begin
            e = cpu_q.pop_front();
            last_rd = e;
            chk(tag, 64'(bus.ReadData), 64'(e));
        end
    endtask

    task automatic chk_ld(input string tag);
        logic [31:0] e;
        if (ld_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, bus.Ld_RData);
        end else begin
            e = ld_q.pop_front();
            last_ld = e;
            chk(tag, 64'(bus.Ld_RData), 64'(e));
        end
    endtask

    initial begin
        Rst           = 1'b0;
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.Address   = 32'h0;
        bus.WriteData = 32'h0;
        bus.Ld_Req    = 1'b0;
        bus.Ld_We     = 1'b0;
        bus.Ld_Addr   = 32'h0;
        bus.Ld_WData  = 32'h0;
        last_rd       = 32'h0;
        last_ld       = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        // reset with a read request pending: strobes must stay low
        cyc(); cyc();
        chk("rst_stall",    64'(bus.Stall),    64'(0));
        chk("rst_mem_en",   64'(bus.Mem_En),   64'(0));
        chk("rst_ld_ack",   64'(bus.Ld_Ack),   64'(0));
        chk("rst_readdata", 64'(bus.ReadData), 64'(0));
        chk("rst_ld_rdata", 64'(bus.Ld_RData), 64'(0));

        cyc();
        Rst         = 1'b1;
        bus.MemRead = 1'b0;
        #1;
        chk("idle_mem_en", 64'(bus.Mem_En), 64'(0));

        // CPU store then load
        cyc();
        bus.MemWrite  = 1'b1;
        bus.Address   = 32'h10;
        bus.WriteData = 32'hDEADBEEF;
        ref_mem[4]    = 32'hDEADBEEF;
        #1;
        chk("st_mem_en",  64'(bus.Mem_En),    64'(1));
        chk("st_mem_we",  64'(bus.Mem_We),    64'(1));
        chk("st_addr",    64'(bus.Mem_Addr),  64'(4));
        chk("st_wdata",   64'(bus.Mem_WData), 64'(32'hDEADBEEF));
        chk("st_stall",   64'(bus.Stall),     64'(0));

        cyc();
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
        cpu_q.push_back(ref_mem[4]);
        #1;
        chk("ld_stall",  64'(bus.Stall),  64'(1));
        chk("ld_mem_en", 64'(bus.Mem_En), 64'(1));
        chk("ld_mem_we", 64'(bus.Mem_We), 64'(0));

        cyc();
        #1;
        chk("cpurd_stall",  64'(bus.Stall),  64'(0));
        chk("cpurd_mem_en", 64'(bus.Mem_En), 64'(0));
        chk_rd("cpurd_data");

        cyc();
        bus.MemRead = 1'b0;
        #1;
        chk("rd_hold", 64'(bus.ReadData), 64'(last_rd));

        // loader write then read of 0x20
        cyc();
        bus.Ld_Req   = 1'b1;
        bus.Ld_We    = 1'b1;
        bus.Ld_Addr  = 32'h20;
        bus.Ld_WData = 32'h12345678;
        ref_mem[8]   = 32'h12345678;
        #1;
        chk("lw_mem_en", 64'(bus.Mem_En),   64'(1));
        chk("lw_mem_we", 64'(bus.Mem_We),   64'(1));
        chk("lw_addr",   64'(bus.Mem_Addr), 64'(8));
        chk("lw_stall",  64'(bus.Stall),    64'(0));
        chk("lw_noack",  64'(bus.Ld_Ack),   64'(0));

        cyc();
        #1;
        chk("lw_ack",    64'(bus.Ld_Ack), 64'(1));
        chk("lw_memidle", 64'(bus.Mem_En), 64'(0));
        bus.Ld_Req = 1'b0;

        cyc();
        #1;
        chk("lw_ack_pulse", 64'(bus.Ld_Ack), 64'(0));
        bus.Ld_Req = 1'b1;
        bus.Ld_We  = 1'b0;
        ld_q.push_back(ref_mem[8]);
        #1;
        chk("lr_mem_we", 64'(bus.Mem_We),   64'(0));
        chk("lr_addr",   64'(bus.Mem_Addr), 64'(8));

        cyc();
        #1;
        chk("lr_ack", 64'(bus.Ld_Ack), 64'(1));
        chk_ld("lr_data");
        bus.Ld_Req = 1'b0;

        cyc();
        #1;
        chk("lr_ack_pulse", 64'(bus.Ld_Ack),   64'(0));
        chk("lr_hold",      64'(bus.Ld_RData), 64'(last_ld));

        // continuous stores with a waiting loader: 4 CPU grants, then the loader
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) begin
                bus.Ld_Req   = 1'b1;
                bus.Ld_We    = 1'b1;
                bus.Ld_Addr  = 32'h30;
                bus.Ld_WData = 32'hA5A50001;
                ref_mem[12]  = 32'hA5A50001;
            end
            bus.MemWrite  = 1'b1;
            bus.Address   = 32'h40 + 32'(4 * i);
            bus.WriteData = 32'h1000 + 32'(i);
            ref_mem[16 + i] = 32'h1000 + 32'(i);
            #1;
            chk("starve_cpu_addr",  64'(bus.Mem_Addr), 64'(16 + i));
            chk("starve_cpu_stall", 64'(bus.Stall),    64'(0));
        end

        cyc();
        bus.Address   = 32'h50;
        bus.WriteData = 32'h1004;
        ref_mem[20]   = 32'h1004;
        #1;
        chk("starve_ld_addr",  64'(bus.Mem_Addr),  64'(12));
        chk("starve_ld_wdata", 64'(bus.Mem_WData), 64'(32'hA5A50001));
        chk("starve_ld_stall", 64'(bus.Stall),     64'(1));

        cyc();
        #1;
        chk("starve_done_ack",   64'(bus.Ld_Ack), 64'(1));
        chk("starve_done_stall", 64'(bus.Stall),  64'(1));
        chk("starve_done_idle",  64'(bus.Mem_En), 64'(0));
        bus.Ld_Req = 1'b0;

        cyc();
        #1;
        chk("starve_resume_addr",  64'(bus.Mem_Addr), 64'(20));
        chk("starve_resume_stall", 64'(bus.Stall),    64'(0));
        chk("starve_resume_en",    64'(bus.Mem_En),   64'(1));

        // simultaneous MemRead and Ld_Req with no starvation: CPU first
        cyc();
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
        bus.Address  = 32'h20;
        bus.Ld_Req   = 1'b1;
        bus.Ld_We    = 1'b0;
        bus.Ld_Addr  = 32'h10;
        cpu_q.push_back(ref_mem[8]);
        #1;
        chk("race_cpu_stall", 64'(bus.Stall),    64'(1));
        chk("race_cpu_addr",  64'(bus.Mem_Addr), 64'(8));

        cyc();
        #1;
        chk("race_cpurd_stall", 64'(bus.Stall),  64'(0));
        chk("race_cpurd_noack", 64'(bus.Ld_Ack), 64'(0));
        chk_rd("race_cpurd_data");

        cyc();
        bus.MemRead = 1'b0;
        ld_q.push_back(ref_mem[4]);
        #1;
        chk("race_ld_addr", 64'(bus.Mem_Addr), 64'(4));
        chk("race_ld_en",   64'(bus.Mem_En),   64'(1));

        cyc();
        #1;
        chk("race_ld_ack", 64'(bus.Ld_Ack), 64'(1));
        chk_ld("race_ld_data");
        bus.Ld_Req = 1'b0;

        // reset during CPU_RD
        cyc();
        bus.MemRead = 1'b1;
        bus.Address = 32'h40;
        #1;
        chk("rcpu_stall", 64'(bus.Stall), 64'(1));

        cyc();
        Rst = 1'b0;
        #1;
        chk("rcpu_rst_stall", 64'(bus.Stall),    64'(0));
        chk("rcpu_rst_rdata", 64'(bus.ReadData), 64'(0));
        chk("rcpu_rst_en",    64'(bus.Mem_En),   64'(0));

        cyc();
        Rst = 1'b1;
        cpu_q.push_back(ref_mem[16]);
        #1;
        chk("rcpu_retry_stall", 64'(bus.Stall),  64'(1));
        chk("rcpu_retry_en",    64'(bus.Mem_En), 64'(1));

        cyc();
        #1;
        chk("rcpu_retry_stall_end", 64'(bus.Stall), 64'(0));
        chk_rd("rcpu_retry_data");

        // reset during LD_DONE
        cyc();
        bus.MemRead = 1'b0;
        bus.Ld_Req  = 1'b1;
        bus.Ld_We   = 1'b0;
        bus.Ld_Addr = 32'h44;
        #1;
        chk("rld_grant_en", 64'(bus.Mem_En), 64'(1));

        cyc();
        Rst = 1'b0;
        #1;
        chk("rld_rst_ack",   64'(bus.Ld_Ack),   64'(0));
        chk("rld_rst_rdata", 64'(bus.Ld_RData), 64'(0));
        chk("rld_rst_stall", 64'(bus.Stall),    64'(0));

        cyc();
        #1;
        chk("rld_rst_ack2", 64'(bus.Ld_Ack), 64'(0));
        Rst = 1'b1;
        ld_q.push_back(ref_mem[17]);
        #1;
        chk("rld_retry_en",   64'(bus.Mem_En),   64'(1));
        chk("rld_retry_addr", 64'(bus.Mem_Addr), 64'(17));

        cyc();
        #1;
        chk("rld_retry_ack", 64'(bus.Ld_Ack), 64'(1));
        chk_ld("rld_retry_data");
        bus.Ld_Req = 1'b0;

        // MemRead and MemWrite together: store only, no stall
        cyc();
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.Address   = 32'h60;
        bus.WriteData = 32'hCAFEF00D;
        ref_mem[24]   = 32'hCAFEF00D;
        #1;
        chk("rw_mem_we", 64'(bus.Mem_We), 64'(1));
        chk("rw_mem_en", 64'(bus.Mem_En), 64'(1));
        chk("rw_stall",  64'(bus.Stall),  64'(0));

        cyc();
        bus.MemWrite = 1'b0;
        cpu_q.push_back(ref_mem[24]);
        #1;
        chk("rw_idle_rd_stall", 64'(bus.Stall),  64'(1));
        chk("rw_idle_noack",    64'(bus.Ld_Ack), 64'(0));

        cyc();
        #1;
        chk_rd("rw_readback");

        cyc();
        bus.MemRead = 1'b0;
        #1;
        chk("end_stall", 64'(bus.Stall), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
